// File: rtl/led_panel_pkg.sv
// Shared constants, types and helpers for the LED panel column-driver models.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   PANEL_COLS    default column count of one driver
//   BRIGHT_W_DEF  default global-brightness code width
//   bright_t      brightness code at the default width
//   pwm_period()  PWM period in clk cycles for a given code width
package led_panel_pkg;

    localparam int PANEL_COLS   = 16;
    localparam int BRIGHT_W_DEF = 4;

    typedef logic [BRIGHT_W_DEF-1:0] bright_t;

    // A period of 2^bw-1 cycles lets code 0 mean "never on" and the
    // all-ones code mean "always on" with a plain less-than compare.
    function automatic int pwm_period(input int bw);
        return (1 << bw) - 1;
    endfunction

endpackage

// File: rtl/led_shift_latch_if.sv
// Control/data bundle between a row-scan controller and one column driver.
// Latency: n/a (wiring only).
// Backpressure: none; strobes are sampled every clk.
//
// Signals:
//   sdi, shift_en, lat, n_oe, bright   controller -> driver
//   sdo, latch_q, drv, bit_cnt, full,
//   ovf                                driver -> controller / LED array
// Modports: master = controller side, slave = driver side.
interface led_shift_latch_if
    import led_panel_pkg::*;
#(
    parameter int WIDTH    = PANEL_COLS,
    parameter int BRIGHT_W = BRIGHT_W_DEF
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic                sdi;
    logic                shift_en;
    logic                lat;
    logic                n_oe;
    logic [BRIGHT_W-1:0] bright;
    logic                sdo;
    logic [WIDTH-1:0]    latch_q;
    logic [WIDTH-1:0]    drv;
    logic [CNT_W-1:0]    bit_cnt;
    logic                full;
    logic                ovf;

    modport master (
        output sdi, shift_en, lat, n_oe, bright,
        input  sdo, latch_q, drv, bit_cnt, full, ovf
    );

    modport slave (
        input  sdi, shift_en, lat, n_oe, bright,
        output sdo, latch_q, drv, bit_cnt, full, ovf
    );

endinterface

// File: rtl/led_pwm_gen.sv
// Global-brightness PWM gate: free-running counter compared against bright.
// Latency: pwm_on is combinational from the counter and bright (new code seen at once).
// Backpressure: none; counter runs every clk after CLR release.
//
// Ports:
//   clk     system clock
//   CLR     asynchronous active-high reset (counter to 0)
//   bright  brightness code; on-time is bright cycles per period
//   pwm_on  high while the counter is below bright
module led_pwm_gen
    import led_panel_pkg::*;
#(
    parameter int BRIGHT_W = BRIGHT_W_DEF
) (
    input  logic                clk,
    input  logic                CLR,
    input  logic [BRIGHT_W-1:0] bright,
    output logic                pwm_on
);
    // Last count of the period; the all-ones value is never reached so that
    // the all-ones brightness code compares as always on.
    localparam logic [BRIGHT_W-1:0] CNT_LAST = BRIGHT_W'(pwm_period(BRIGHT_W) - 1);

    logic [BRIGHT_W-1:0] pwm_cnt;
    logic [BRIGHT_W-1:0] pwm_cnt_nxt;

    always_comb begin
        pwm_cnt_nxt = pwm_cnt + 1'b1;
        if (pwm_cnt == CNT_LAST) begin
            pwm_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt_nxt;
        end
    end

    assign pwm_on = (pwm_cnt < bright);

endmodule

// File: rtl/led_shift_latch.sv
// HUB75-style column driver: serial-in shift register, parallel latch, OE + PWM gated drive.
// Latency: lat at edge N -> latch_q after N -> drv after N+1; sdo is the last shift stage.
// Backpressure: none; shift/lat strobes act every clk, over-shifting is flagged in sticky ovf.
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   CLR      asynchronous active-high reset, clears every register
//   bus      led_shift_latch_if slave: sdi/shift_en/lat/n_oe/bright in;
//            sdo/latch_q/drv/bit_cnt/full/ovf out
module led_shift_latch
    import led_panel_pkg::*;
#(
    parameter int WIDTH    = PANEL_COLS,
    parameter int BRIGHT_W = BRIGHT_W_DEF
) (
    input  logic             clk,
    input  logic             CLR,
    led_shift_latch_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic [WIDTH-1:0] latch_q;
    logic [WIDTH-1:0] latch_nxt;
    logic [WIDTH-1:0] drv;
    logic [WIDTH-1:0] drv_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_nxt;
    logic             ovf;
    logic             ovf_nxt;
    logic             full;
    logic             pwm_on;

    led_pwm_gen #(
        .BRIGHT_W (BRIGHT_W)
    ) u_pwm (
        .clk    (clk),
        .CLR    (CLR),
        .bright (bus.bright),
        .pwm_on (pwm_on)
    );

    assign full = (bit_cnt == CNT_FULL);

    // Shift register: MSB-first, the first bit in reaches bit WIDTH-1
    // after WIDTH shifts and then leaves through sdo.
    always_comb begin
        sr_nxt = sr;
        if (bus.shift_en) begin
            sr_nxt = {sr[WIDTH-2:0], bus.sdi};
        end
    end

    // Latch captures the pre-edge shift register, so a shift in the same
    // cycle only affects what the next latch will see.
    always_comb begin
        latch_nxt = latch_q;
        if (bus.lat) begin
            latch_nxt = sr;
        end
    end

    // Bit count restarts on latch; a shift in the latch cycle is the first
    // bit of the next word, hence restart at 1 rather than 0.
    always_comb begin
        bit_cnt_nxt = bit_cnt;
        ovf_nxt     = ovf;
        if (bus.lat) begin
            bit_cnt_nxt = CNT_W'(bus.shift_en);
            ovf_nxt     = 1'b0;
        end else if (bus.shift_en) begin
            if (full) begin
                ovf_nxt = 1'b1;
            end else begin
                bit_cnt_nxt = bit_cnt + 1'b1;
            end
        end
    end

    // Drive uses the current latch contents, giving one extra stage of
    // latency from lat to the LEDs.
    always_comb begin
        drv_nxt = '0;
        if (!bus.n_oe && pwm_on) begin
            drv_nxt = latch_q;
        end
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            sr      <= '0;
            latch_q <= '0;
            drv     <= '0;
            bit_cnt <= '0;
            ovf     <= 1'b0;
        end else begin
            sr      <= sr_nxt;
            latch_q <= latch_nxt;
            drv     <= drv_nxt;
            bit_cnt <= bit_cnt_nxt;
            ovf     <= ovf_nxt;
        end
    end

    assign bus.sdo     = sr[WIDTH-1];
    assign bus.latch_q = latch_q;
    assign bus.drv     = drv;
    assign bus.bit_cnt = bit_cnt;
    assign bus.full    = full;
    assign bus.ovf     = ovf;

endmodule
